// File: rtl/multicycle_control_if.sv
// Instruction-memory fetch handshake between the control unit (master) and imem (slave).
interface multicycle_control_if #(
    parameter int D_WIDTH = 32
);
    logic               req;
    logic [D_WIDTH-1:0] addr;
    logic               ack;
    logic [D_WIDTH-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control unit: fetches over req/ack, decodes, and drives
// the register-file/ALU datapath for one execute cycle per instruction.
//
// state  | meaning
// FETCH  | request imem at pc, load IR on ack
// DECODE | classify IR, legal -> EXEC, otherwise -> TRAP
// EXEC   | drive datapath, resolve branch on eq, update pc/instret
// TRAP   | absorbing after an illegal instruction, exits only by reset
module multicycle_control #(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 5,
    parameter logic [D_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master imem,
    input  logic                 eq,
    output logic                 regWrite,
    output logic [2:0]           ALUctrl,
    output logic [A_WIDTH-1:0]   rs1,
    output logic [A_WIDTH-1:0]   rs2,
    output logic [A_WIDTH-1:0]   rd,
    output logic                 ALUsrc,
    output logic [D_WIDTH-1:0]   ImmOp,
    output logic [D_WIDTH-1:0]   pc,
    output logic [31:0]          instret,
    output logic                 illegal
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, TRAP} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t             state;
    logic [D_WIDTH-1:0] ir;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [D_WIDTH-1:0] bimm;
    logic               legal;
    logic               wr_en;
    logic               is_branch;
    logic               taken;
    logic [2:0]         alu_op;
    logic               alu_src;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[15 +: A_WIDTH];
    assign rs2    = ir[20 +: A_WIDTH];
    assign rd     = ir[7 +: A_WIDTH];
    assign ImmOp  = {{(D_WIDTH-12){ir[31]}}, ir[31:20]};
    assign bimm   = {{(D_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    always_comb begin
        legal     = 1'b0;
        wr_en     = 1'b0;
        is_branch = 1'b0;
        alu_op    = 3'b000;
        alu_src   = 1'b0;
        case (opcode)
            OPC_OP: begin
                wr_en = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin alu_op = 3'b000; legal = 1'b1; end
                    {7'b0100000, 3'b000}: begin alu_op = 3'b001; legal = 1'b1; end
                    {7'b0000000, 3'b111}: begin alu_op = 3'b010; legal = 1'b1; end
                    {7'b0000000, 3'b110}: begin alu_op = 3'b011; legal = 1'b1; end
                    {7'b0000000, 3'b010}: begin alu_op = 3'b101; legal = 1'b1; end
                    default:              legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                wr_en   = 1'b1;
                alu_src = 1'b1;
                case (funct3)
                    3'b000:  begin alu_op = 3'b000; legal = 1'b1; end
                    3'b111:  begin alu_op = 3'b010; legal = 1'b1; end
                    3'b110:  begin alu_op = 3'b011; legal = 1'b1; end
                    3'b010:  begin alu_op = 3'b101; legal = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                alu_op    = 3'b001;
                legal     = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            default: legal = 1'b0;
        endcase
    end

    // funct3[0] distinguishes bne from beq; only those two reach EXEC
    assign taken     = is_branch && (funct3[0] ? !eq : eq);
    assign ALUctrl   = alu_op;
    assign ALUsrc    = alu_src;
    assign regWrite  = (state == EXEC) && wr_en && (rd != '0);
    assign imem.req  = rst_n && (state == FETCH);
    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= PC_RESET;
            ir      <= D_WIDTH'(32'h0000_0013);
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.ack) begin
                        ir    <= imem.rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        state   <= TRAP;
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    pc      <= taken ? pc + bimm : pc + D_WIDTH'(4);
                    instret <= instret + 32'd1;
                    state   <= FETCH;
                end
                default: state <= TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected datapath
// controls are queued at fetch and compared when the DUT reaches EXEC.
module tb_multicycle_control;
    typedef struct {
        logic [31:0] instr;
        logic        rw;
        logic [2:0]  alu;
        logic        src;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] next_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eq = 1'b0;
    logic        regWrite;
    logic [2:0]  ALUctrl;
    logic [4:0]  rs1, rs2, rd;
    logic        ALUsrc;
    logic [31:0] ImmOp;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        illegal;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instret = 32'h0;
    exp_t        sb[$];

    multicycle_control_if #(.D_WIDTH(32)) imem_bus ();

    multicycle_control #(.D_WIDTH(32), .A_WIDTH(5), .PC_RESET(32'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem     (imem_bus.master),
        .eq       (eq),
        .regWrite (regWrite),
        .ALUctrl  (ALUctrl),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .ALUsrc   (ALUsrc),
        .ImmOp    (ImmOp),
        .pc       (pc),
        .instret  (instret),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    // Drives one instruction through FETCH/DECODE/EXEC; all sampling at negedge.
    task automatic run_instr(input string name, input exp_t e, input int delay,
                             input logic eqv, input bit ack_hold);
        exp_t got;
        sb.push_back(e);
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (imem_bus.req !== 1'b1 || imem_bus.addr !== exp_pc) begin
                errors++;
                $display("FAIL %s fetch_wait%0d: req=%b addr=%0h expected req=1 addr=%0h",
                         name, i, imem_bus.req, imem_bus.addr, exp_pc);
            end
            @(negedge clk);
        end
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== exp_pc) begin
            errors++;
            $display("FAIL %s fetch_ack: req=%b addr=%0h expected req=1 addr=%0h",
                     name, imem_bus.req, imem_bus.addr, exp_pc);
        end
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = e.instr;
        @(negedge clk);
        if (!ack_hold) imem_bus.ack = 1'b0;
        imem_bus.rdata = 32'hFFFF_FFFF;
        eq = eqv;
        checks++;
        if (imem_bus.req !== 1'b0 || regWrite !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s decode: req=%b regWrite=%b illegal=%b expected 0 0 0",
                     name, imem_bus.req, regWrite, illegal);
        end
        @(negedge clk);
        got = sb.pop_front();
        checks++;
        if (regWrite !== got.rw || ALUctrl !== got.alu || ALUsrc !== got.src ||
            rd !== got.rd || rs1 !== got.rs1 || rs2 !== got.rs2 || ImmOp !== got.imm ||
            imem_bus.req !== 1'b0) begin
            errors++;
            $display("FAIL %s exec: rw=%b alu=%b src=%b rd=%0d rs1=%0d rs2=%0d imm=%0h req=%b expected rw=%b alu=%b src=%b rd=%0d rs1=%0d rs2=%0d imm=%0h req=0",
                     name, regWrite, ALUctrl, ALUsrc, rd, rs1, rs2, ImmOp, imem_bus.req,
                     got.rw, got.alu, got.src, got.rd, got.rs1, got.rs2, got.imm);
        end
        imem_bus.ack = 1'b0;
        @(negedge clk);
        exp_pc = got.next_pc;
        exp_instret = exp_instret + 32'd1;
        checks++;
        if (pc !== exp_pc || instret !== exp_instret || imem_bus.req !== 1'b1 || regWrite !== 1'b0) begin
            errors++;
            $display("FAIL %s retire: pc=%0h instret=%0d req=%b rw=%b expected pc=%0h instret=%0d req=1 rw=0",
                     name, pc, instret, imem_bus.req, regWrite, exp_pc, exp_instret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (pc !== 32'h0 || imem_bus.req !== 1'b0 || instret !== 32'h0 ||
                illegal !== 1'b0 || regWrite !== 1'b0) begin
                errors++;
                $display("FAIL reset: pc=%0h req=%b instret=%0d illegal=%b rw=%b expected 0 0 0 0 0",
                         pc, imem_bus.req, instret, illegal, regWrite);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%0h expected req=1 addr=0",
                     imem_bus.req, imem_bus.addr);
        end
        exp_pc = 32'h0;
        exp_instret = 32'h0;
    endtask

    task automatic test_addi();
        run_instr("addi", '{32'h0050_0093, 1'b1, 3'b000, 1'b1, 5'd1, 5'd0, 5'd5,
                            32'h5, 32'h4}, 0, 1'b0, 1'b0);
    endtask

    task automatic test_sub_delay();
        run_instr("sub", '{32'h4020_81B3, 1'b1, 3'b001, 1'b0, 5'd3, 5'd1, 5'd2,
                           32'h402, 32'h8}, 3, 1'b0, 1'b0);
    endtask

    task automatic test_rd_zero();
        run_instr("add_x0", '{32'h0020_8033, 1'b0, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2,
                              32'h2, 32'hC}, 0, 1'b1, 1'b0);
    endtask

    task automatic test_ori();
        run_instr("ori", '{32'h07F0_E293, 1'b1, 3'b011, 1'b1, 5'd5, 5'd1, 5'd31,
                           32'h7F, 32'h10}, 1, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        // ack held through DECODE/EXEC with junk data; it must not reload IR
        run_instr("bne_taken", '{32'hFE20_9CE3, 1'b0, 3'b001, 1'b0, 5'd25, 5'd1, 5'd2,
                                 32'hFFFF_FFE2, 32'h8}, 0, 1'b0, 1'b1);
        run_instr("and", '{32'h0020_F233, 1'b1, 3'b010, 1'b0, 5'd4, 5'd1, 5'd2,
                           32'h2, 32'hC}, 0, 1'b0, 1'b0);
        run_instr("slti", '{32'hFFF0_A313, 1'b1, 3'b101, 1'b1, 5'd6, 5'd1, 5'd31,
                            32'hFFFF_FFFF, 32'h10}, 2, 1'b1, 1'b0);
        run_instr("beq_not_taken", '{32'hFE20_8CE3, 1'b0, 3'b001, 1'b0, 5'd25, 5'd1, 5'd2,
                                     32'hFFFF_FFE2, 32'h14}, 0, 1'b0, 1'b0);
        run_instr("beq_taken", '{32'hFE20_8CE3, 1'b0, 3'b001, 1'b0, 5'd25, 5'd1, 5'd2,
                                 32'hFFFF_FFE2, 32'hC}, 0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem_bus.ack = 1'b0;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_decode: illegal=%b expected 0", illegal);
        end
        @(negedge clk);
        imem_bus.ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (illegal !== 1'b1 || imem_bus.req !== 1'b0 || pc !== exp_pc ||
                instret !== exp_instret || regWrite !== 1'b0) begin
                errors++;
                $display("FAIL trap%0d: illegal=%b req=%b pc=%0h instret=%0d rw=%b expected 1 0 %0h %0d 0",
                         i, illegal, imem_bus.req, pc, instret, regWrite, exp_pc, exp_instret);
            end
            @(negedge clk);
        end
        imem_bus.ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (illegal !== 1'b0 || pc !== 32'h0 || instret !== 32'h0 || imem_bus.req !== 1'b0) begin
            errors++;
            $display("FAIL trap_reset: illegal=%b pc=%0h instret=%0d req=%b expected 0 0 0 0",
                     illegal, pc, instret, imem_bus.req);
        end
        rst_n = 1'b1;
        exp_pc = 32'h0;
        exp_instret = 32'h0;
        #1;
        run_instr("addi_after_trap", '{32'h0050_0093, 1'b1, 3'b000, 1'b1, 5'd1, 5'd0, 5'd5,
                                       32'h5, 32'h4}, 0, 1'b0, 1'b0);
    endtask

    initial begin
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_sub_delay();
        test_rd_zero();
        test_ori();
        test_branch();
        test_illegal();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit that drives the register-file/ALU datapath from the instruction-memory side. It fetches a 32-bit RV32I instruction over a req/ack handshake and latches it in an instruction register. It then decodes the instruction and, for one execute cycle, drives the datapath inputs (`regWrite`, `ALUctrl`, `rs1`, `rs2`, `rd`, `ALUsrc`, `ImmOp`), using the datapath's `eq` flag to resolve branches. It owns the PC and a retired-instruction counter, and it sits between instruction memory and the datapath.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_0000: PC value after reset.
- `D_WIDTH`, default 32: data, instruction and PC width.
- `A_WIDTH`, default 5: register address width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  D_WIDTH  fetch address; equals PC.
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  D_WIDTH  instruction word.
- `eq`  in  1  datapath comparison flag; 1 when ALU operands are equal.
- `regWrite`  out  1  register write enable.
- `ALUctrl`  out  3  ALU operation.
- `rs1`, `rs2`, `rd`  out  A_WIDTH  register addresses taken from IR[19:15], IR[24:20] and IR[11:7].
- `ALUsrc`  out  1  0 selects register operand 2; 1 selects ImmOp.
- `ImmOp`  out  D_WIDTH  sign-extended I-immediate from IR[31:20].
- `pc`  out  D_WIDTH  current PC.
- `instret`  out  32  retired-instruction count.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States are FETCH, DECODE, EXEC and TRAP.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc.
  - On a cycle with `imem_ack`=1: IR is loaded with `imem_rdata` and the next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE (1 cycle): classify IR.
  - Legal instructions go to EXEC.
  - Anything else goes to TRAP, with `illegal` set at that edge.
- Legal set:
  - OP (opcode 0110011): add, sub, and, or, slt.
  - OP-IMM (opcode 0010011): addi, andi, ori, slti.
  - BRANCH (opcode 1100011): beq (funct3 000), bne (funct3 001).
- ALUctrl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- EXEC (1 cycle):
  - OP: `ALUsrc`=0; ALUctrl from funct3/funct7; `regWrite`=1 unless `rd`==0.
  - OP-IMM: `ALUsrc`=1; ALUctrl from funct3; `regWrite`=1 unless `rd`==0.
  - BRANCH: `ALUsrc`=0, `ALUctrl`=001, `regWrite`=0. Taken if (beq && eq) or (bne && !eq).
  - PC update at the end of EXEC: taken → pc + sign-extended B-immediate {IR[31],IR[7],IR[30:25],IR[11:8],0}; otherwise pc+4.
  - Arithmetic on the PC is modulo 2^32.
  - `instret`+1 at the end of EXEC, wrapping modulo 2^32.
  - Next state is FETCH.
- TRAP:
  - Absorbing: `imem_req`=0 and `regWrite`=0.
  - pc and `instret` are frozen; only reset exits TRAP.
- `regWrite` is 0 in every state except EXEC.
- `ALUctrl` and `ALUsrc` are don't-care outside EXEC; they are driven as decoded from IR.

## Timing
- Reset values, applied at the first edge with `rst_n`=0:
  - State FETCH.
  - pc=PC_RESET.
  - IR=32'h0000_0013 (nop).
  - `instret`=0 and `illegal`=0.
  - `regWrite`=0.
  - `imem_req`=0 while `rst_n`=0.
- Fetch timing:
  - `imem_req` rises in the first cycle with `rst_n`=1.
  - `imem_ack` may assert in the same cycle as `imem_req`.
- Minimum instruction time is 3 cycles (FETCH, DECODE, EXEC); each ack wait cycle adds one.
- `imem_ack` outside FETCH is ignored.
- `imem_rdata` is sampled only at the ack edge.
- `eq` is sampled combinationally during EXEC only.
- Register write occurs at the EXEC→FETCH edge, together with the PC update.
- Reset mid-operation:
  - Reset has priority over all transitions.
  - Reset during EXEC suppresses the pc/instret update; the datapath write in that cycle is not guaranteed.
  - Reset during FETCH with a simultaneous ack discards the instruction.
- `rs1`, `rs2`, `rd` and `ImmOp` are combinational from IR, so they are stable from DECODE through EXEC.

## Test plan
- Reset:
  - Stimulus: hold `rst_n`=0 for 2 cycles with PC_RESET=0, then release.
  - Required: pc=0, `imem_req`=0 during reset, `imem_req`=1 the cycle after release, `instret`=0, `illegal`=0.
- addi:
  - Stimulus: ack 32'h0050_0093 (addi x1,x0,5) in the same cycle as req.
  - Required: two cycles later EXEC has `regWrite`=1, `rd`=1, `rs1`=0, `ALUsrc`=1, `ALUctrl`=000, `ImmOp`=5; next pc=4, `instret`=1.
- sub with ack delay:
  - Stimulus: 32'h4020_81B3 (sub x3,x1,x2), ack delayed 3 cycles.
  - Required: FETCH lasts 4 cycles; EXEC has `ALUsrc`=0, `ALUctrl`=001, `rd`=3; pc advances by 4.
- bne taken and beq not taken:
  - Stimulus: bne x1,x2,-8 (32'hFE20_9CE3) at pc=16 with `eq`=0.
  - Required: pc=8 and `regWrite`=0 in EXEC.
  - Stimulus: beq with the same offset and `eq`=0.
  - Required: pc=20.
- rd=0 suppression:
  - Stimulus: add x0,x1,x2 (32'h0020_8033).
  - Required: `regWrite`=0 in EXEC, `instret` increments.
- Illegal instruction:
  - Stimulus: ack 32'hFFFF_FFFF.
  - Required: `illegal`=1 after DECODE; `imem_req` stays 0 and pc/`instret` stay frozen for ≥10 cycles; `rst_n` pulse clears `illegal` and restarts fetch at PC_RESET.
